kernel_result_fifo: RTL
=======================

Name: kernel_result_fifo

Overview:
- Downstream of the pixel FSM.
- Captures each 16-bit kernel result (`data_out`) and its 4-bit pixel tag (`pxl_q`) on the rising edge of `kernel_done_o`.
- Buffers results in a first-word-fall-through FIFO so the management SoC can drain them over Wishbone without losing results between polls.
- Provides status, a saturating overflow counter and a threshold interrupt.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, 2..64).
- AW, 3, pointer width, log2(DEPTH).
- IRQ_THRESH, 4, `irq_o` asserts when count >= IRQ_THRESH (1..DEPTH).

Ports:
- clk  in  1  system clock (wb_clk_i at top level)
- reset  in  1  synchronous, active-high reset
- kernel_done_i  in  1  level from pixel FSM; rising edge = result ready
- data_i  in  16  kernel result, sampled on the same cycle the edge is detected
- tag_i  in  4  pixel tag (`pxl_q`), sampled with data_i
- rd_en_i  in  1  one-cycle pop request from the Wishbone register decode
- clr_i  in  1  one-cycle flush request
- rd_data_o  out  32  {valid, 11'b0, tag, data} of the head entry
- count_o  out  AW+1  occupancy, 0..DEPTH
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH
- ovf_cnt_o  out  8  dropped-result counter, saturates at 255
- udf_o  out  1  sticky flag: pop attempted while empty
- irq_o  out  1  registered, count >= IRQ_THRESH

Behaviour:
- Reset and output reset values:
  - Reset is synchronous, active-high, applied on posedge clk.
  - All outputs and state clear on reset: pointers 0, count 0, empty_o 1, full_o 0, ovf_cnt_o 0, udf_o 0, irq_o 0, rd_data_o 0, edge register `done_q` 0.
  - Because `done_q` clears, a kernel_done_i held high through reset release produces exactly one push on the first cycle after reset.
- Edge detect:
  - `done_q` <= kernel_done_i every cycle.
  - push_req = kernel_done_i & ~done_q.
  - A level held high pushes once; a new push needs a low cycle first.
- Storage:
  - Entry is 20 bits {tag_i, data_i}, written at wr_ptr on the push_req cycle.
  - Pointers are AW bits and wrap modulo DEPTH.
  - count is tracked separately as AW+1 bits.
- Read (FWFT):
  - rd_data_o is combinational from mem[rd_ptr] while non-empty: bit 31 = 1, bits 19:16 = tag, bits 15:0 = data, other bits 0.
  - When empty, rd_data_o = 32'h0 (valid = 0).
  - rd_en_i with count > 0 advances rd_ptr; the next head appears the following cycle.
- Per-cycle priority:
  1. clr_i: pointers and count go to 0, ovf_cnt_o and udf_o clear. A push or pop in the same cycle is discarded. `done_q` still updates.
  2. Push and pop in the same cycle:
     - Non-empty, not full: both happen, count unchanged.
     - Full: pop frees the slot, the push is accepted, count stays DEPTH, no overflow.
     - Empty: push only (no bypass), the pop is counted as underflow (udf_o <= 1), count becomes 1.
  3. Push only:
     - Full: entry dropped, pointers unchanged, ovf_cnt_o increments, holding at 255.
     - Otherwise: write the entry, count +1.
  4. Pop only:
     - Empty: udf_o <= 1, no pointer change.
     - Otherwise: count -1.
- Flags:
  - empty_o and full_o are derived from the registered count.
  - irq_o is registered from the next-state count, so it goes high the cycle count reaches IRQ_THRESH and low the cycle count drops below it.
- Latency:
  - Push edge at cycle N gives count_o and rd_data_o updated at N+1.
  - Pop at cycle N gives the new head at N+1.
- No X propagation: memory contents are not reset, but valid = 0 masks the head while empty.

Decomposition:
- Shared package `mixpix_pkg`:
  - Entry field offsets: DATA_LSB = 0, TAG_LSB = 16, VALID_BIT = 31.
  - ENTRY_W = 20.
  - Default DEPTH / IRQ_THRESH.
  - Wishbone offsets for the new registers: FIFO_DATA = 32 (read pops), FIFO_STATUS = 36 ({udf, ovf_cnt, full, empty, count}), FIFO_CLR = 40.
- One natural sub-module, `sync_fifo_fwft`: parameterised memory, pointers and count. The wrapper adds edge detect, overflow/underflow accounting and the interrupt.

Test Plan:
- Basic capture and drain: reset; three `kernel_done_i` pulses with (data, tag) = (16'h1234, 4'h1), (16'hBEEF, 4'h2), (16'h0001, 4'hF) -> count_o = 3, rd_data_o = 32'h8001_1234. Three pops -> heads 32'h8002_BEEF, 32'h800F_0001, then 32'h0, empty_o = 1.
- Overflow: DEPTH = 8; 10 pushes with no pops -> full_o = 1, count_o = 8, ovf_cnt_o = 2, head = first entry. Then 300 further pushes -> ovf_cnt_o stays at 255.
- Level hold and reset release: kernel_done_i held high 20 cycles -> exactly one push. kernel_done_i held high across reset deassertion -> count_o = 1 on the cycle after reset.
- Simultaneous push and pop when full: FIFO full, same-cycle push of 16'hAAAA and pop -> count_o stays 8, ovf_cnt_o unchanged, 16'hAAAA is the last entry drained. Same-cycle push and pop when empty -> count_o = 1, udf_o = 1.
- IRQ and clear: IRQ_THRESH = 4; 3 pushes -> irq_o = 0; 4th push -> irq_o = 1 next cycle. clr_i together with a push -> count_o = 0, irq_o = 0, ovf_cnt_o = 0, udf_o = 0, no entry retained.
- Wrap-around: 5 pushes, 5 pops, 8 pushes -> data order preserved across the pointer wrap, count_o = 8, full_o = 1.

Source files
------------

// File: rtl/mixpix_pkg.sv
// Shared definitions for the mixpix kernel-result path.
// Covers the entry layout, FIFO defaults, the Wishbone register map and head-word packing.
package mixpix_pkg;

   localparam int DATA_LSB  = 0;
   localparam int TAG_LSB   = 16;
   localparam int VALID_BIT = 31;
   localparam int DATA_W    = 16;
   localparam int TAG_W     = 4;
   localparam int ENTRY_W   = 20;

   localparam int FIFO_DEPTH_DEF      = 8;
   localparam int FIFO_AW_DEF         = 3;
   localparam int FIFO_IRQ_THRESH_DEF = 4;

   localparam logic [7:0] WB_FIFO_DATA   = 8'd32;
   localparam logic [7:0] WB_FIFO_STATUS = 8'd36;
   localparam logic [7:0] WB_FIFO_CLR    = 8'd40;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } entry_t;

   function automatic logic [31:0] head_word(input logic valid, input entry_t entry);
      logic [31:0] w_word;
      w_word = 32'h0000_0000;
      if (valid) begin
         w_word[VALID_BIT]            = 1'b1;
         w_word[TAG_LSB +: TAG_W]     = entry.tag;
         w_word[DATA_LSB +: DATA_W]   = entry.data;
      end else begin
         w_word = 32'h0000_0000;
      end
      return w_word;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] w_next;
      if (value == 8'hFF) begin
         w_next = value;
      end else begin
         w_next = value + 8'd1;
      end
      return w_next;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through storage: memory, wrapping pointers and occupancy count.
// Callers only issue write/read strobes that are already legal for the current occupancy.
module sync_fifo_fwft
   import mixpix_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int AW    = FIFO_AW_DEF,
   parameter int W     = ENTRY_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_wr_en,
   input  logic [W-1:0] i_wr_data,
   input  logic         i_rd_en,
   output logic [W-1:0] o_rd_data,
   output logic [AW:0]  o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   // Storage array; left unreset because the wrapper masks the head while empty.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; a flush behaves like reset.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (i_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({i_wr_en, i_rd_en})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/kernel_result_fifo.sv
// Captures kernel results on the rising edge of kernel_done_i into an FWFT FIFO,
// with overflow/underflow accounting and a registered occupancy-threshold interrupt.
module kernel_result_fifo
   import mixpix_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH_DEF,
   parameter int AW         = FIFO_AW_DEF,
   parameter int IRQ_THRESH = FIFO_IRQ_THRESH_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          kernel_done_i,
   input  logic [15:0]   data_i,
   input  logic [3:0]    tag_i,
   input  logic          rd_en_i,
   input  logic          clr_i,
   output logic [31:0]   rd_data_o,
   output logic [AW:0]   count_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [7:0]    ovf_cnt_o,
   output logic          udf_o,
   output logic          irq_o
);

   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] THRESH_C = (AW+1)'(IRQ_THRESH);

   logic        r_done_q;
   logic [7:0]  r_ovf_cnt;
   logic        r_udf;
   logic        r_irq;

   logic        w_push_req;
   logic        w_push_ok;
   logic        w_pop_ok;
   logic        w_ovf_evt;
   logic        w_udf_evt;
   logic        w_empty;
   logic        w_full;
   logic [AW:0] w_count;
   logic [AW:0] w_count_nxt;
   entry_t      w_entry;
   entry_t      w_head;

   assign w_entry    = '{tag: tag_i, data: data_i};
   assign w_push_req = kernel_done_i & ~r_done_q;
   assign w_empty    = (w_count == {(AW+1){1'b0}});
   assign w_full     = (w_count == DEPTH_C);

   // Arbitrate flush, push and pop; a pop on a full FIFO frees the slot for a same-cycle push.
   always_comb begin
      w_push_ok   = 1'b0;
      w_pop_ok    = 1'b0;
      w_ovf_evt   = 1'b0;
      w_udf_evt   = 1'b0;
      w_count_nxt = w_count;
      if (clr_i) begin
         w_count_nxt = {(AW+1){1'b0}};
      end else begin
         w_pop_ok  = rd_en_i & ~w_empty;
         w_udf_evt = rd_en_i & w_empty;
         w_push_ok = w_push_req & (~w_full | w_pop_ok);
         w_ovf_evt = w_push_req & w_full & ~w_pop_ok;
         case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = w_count + (AW+1)'(1);
            2'b01:   w_count_nxt = w_count - (AW+1)'(1);
            default: w_count_nxt = w_count;
         endcase
      end
   end

   // Edge register, sticky status and interrupt (irq follows next-state occupancy).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done_q  <= 1'b0;
         r_ovf_cnt <= 8'd0;
         r_udf     <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_done_q <= kernel_done_i;
         r_irq    <= (w_count_nxt >= THRESH_C);
         if (clr_i) begin
            r_ovf_cnt <= 8'd0;
            r_udf     <= 1'b0;
         end else begin
            if (w_ovf_evt) begin
               r_ovf_cnt <= sat_inc8(r_ovf_cnt);
            end
            if (w_udf_evt) begin
               r_udf <= 1'b1;
            end
         end
      end
   end

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (clr_i),
      .i_wr_en   (w_push_ok),
      .i_wr_data (w_entry),
      .i_rd_en   (w_pop_ok),
      .o_rd_data (w_head),
      .o_count   (w_count)
   );

   assign rd_data_o = head_word(~w_empty, w_head);
   assign count_o   = w_count;
   assign empty_o   = w_empty;
   assign full_o    = w_full;
   assign ovf_cnt_o = r_ovf_cnt;
   assign udf_o     = r_udf;
   assign irq_o     = r_irq;

endmodule
